// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter for an OBI-style data memory port
//
// Purpose:
//   Merges the core LSU data port (requester 0) and a secondary master
//   (requester 1) onto one downstream OBI-style port. Arbitration is
//   round-robin. The address phase stays locked to one requester until it is
//   granted. Requester IDs are queued in order so that responses can be
//   routed back to the requester that issued them.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   m_req/m_we/m_is_cap [1:0]    per-requester request, write, capability flag
//   m_be [1:0][3:0]              per-requester byte enables
//   m_addr [1:0][31:0]           per-requester byte address
//   m_wdata [1:0][32:0]          per-requester write data (bit 32 = tag)
//   m_flag [1:0][7:0]            per-requester sideband flags
//   m_gnt/m_rvalid/m_err [1:0]   per-requester grant, response valid, error
//   m_rdata [32:0]               shared read data, qualified by m_rvalid
//   s_*                          downstream address phase and response phase
//   proto_err                    sticky: response seen with nothing outstanding
//   stat_gnt0/stat_gnt1/stat_stall  statistics counters
//
// Optional feature:
//   DMEM_ARB_STATS_EN - when defined, saturating 32-bit statistics counters
//   are built. When it is undefined, the stat outputs are tied to zero.

module dmem_arbiter #(
   parameter int MAX_OUTST = 4,
   parameter int OID_W     = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       m_req,
   input  logic [1:0]       m_we,
   input  logic [1:0]       m_is_cap,
   input  logic [1:0][3:0]  m_be,
   input  logic [1:0][31:0] m_addr,
   input  logic [1:0][32:0] m_wdata,
   input  logic [1:0][7:0]  m_flag,
   output logic [1:0]       m_gnt,
   output logic [1:0]       m_rvalid,
   output logic [1:0]       m_err,
   output logic [32:0]      m_rdata,
   output logic             s_req,
   output logic             s_we,
   output logic             s_is_cap,
   output logic [3:0]       s_be,
   output logic [31:0]      s_addr,
   output logic [32:0]      s_wdata,
   output logic [7:0]       s_flag,
   input  logic             s_gnt,
   input  logic             s_rvalid,
   input  logic             s_err,
   input  logic [32:0]      s_rdata,
   output logic             proto_err,
   output logic [31:0]      stat_gnt0,
   output logic [31:0]      stat_gnt1,
   output logic [31:0]      stat_stall
);

   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

   typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} lock_state_t;

   lock_state_t          state_q, state_d;
   logic                 lock_id_q;
   logic                 rr_q;
   logic                 sel;
   logic                 full;
   logic                 hs;
   logic                 pop;
   logic                 head;
   logic [OID_W-1:0]     count_q;
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [MAX_OUTST-1:0] fifo_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
   endfunction

   // Lock state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_OPEN;
         lock_id_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_OPEN && s_req && !s_gnt)
            lock_id_q <= sel;
      end
   end

   // Lock next state. Once locked, the lock is held through full stalls
   // (s_req low) and released only in the cycle that is actually granted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OPEN:   if (s_req && !s_gnt) state_d = ST_LOCKED;
         ST_LOCKED: if (hs)              state_d = ST_OPEN;
         default:                        state_d = ST_OPEN;
      endcase
   end

   // Lock output: requester selection
   always_comb begin
      sel = 1'b0;
      if (state_q == ST_LOCKED) begin
         sel = lock_id_q;
      end else begin
         case (m_req)
            2'b10:   sel = 1'b1;
            2'b11:   sel = rr_q;
            default: sel = 1'b0;
         endcase
      end
   end

   // Address-phase forwarding and grant (combinational through-path)
   assign full     = (count_q == OID_W'(MAX_OUTST));
   assign s_req    = m_req[sel] & ~full;
   assign s_we     = m_we[sel];
   assign s_is_cap = m_is_cap[sel];
   assign s_be     = m_be[sel];
   assign s_addr   = m_addr[sel];
   assign s_wdata  = m_wdata[sel];
   assign s_flag   = m_flag[sel];
   assign hs       = s_req & s_gnt;
   assign m_gnt    = hs ? (sel ? 2'b10 : 2'b01) : 2'b00;

   // A response with nothing outstanding is never popped or routed.
   assign pop      = s_rvalid & (count_q != '0);
   assign head     = fifo_q[rd_ptr_q];
   assign m_rvalid = pop ? (head ? 2'b10 : 2'b01) : 2'b00;
   assign m_err    = (pop & s_err) ? (head ? 2'b10 : 2'b01) : 2'b00;
   assign m_rdata  = s_rdata;

   // Round-robin pointer, outstanding ID FIFO and protocol error flag.
   // The full gate on s_req means a push can never coincide with full, so a
   // pop at full frees a slot that s_req can use only from the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q      <= 1'b0;
         fifo_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         proto_err <= 1'b0;
      end else begin
         if (hs) begin
            rr_q             <= ~sel;
            fifo_q[wr_ptr_q] <= sel;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop)
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({hs, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (s_rvalid && count_q == '0)
            proto_err <= 1'b1;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] gnt0_q, gnt1_q, stall_q;
   logic        stall;

   // A stall is a contended cycle, or a cycle where a pending request is
   // blocked by the outstanding limit.
   assign stall = (&m_req) | (full & (|m_req));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt0_q  <= '0;
         gnt1_q  <= '0;
         stall_q <= '0;
      end else begin
         if (hs && !sel && gnt0_q != 32'hFFFF_FFFF)
            gnt0_q <= gnt0_q + 32'd1;
         if (hs && sel && gnt1_q != 32'hFFFF_FFFF)
            gnt1_q <= gnt1_q + 32'd1;
         if (stall && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
      end
   end

   assign stat_gnt0  = gnt0_q;
   assign stat_gnt1  = gnt1_q;
   assign stat_stall = stall_q;
`else
   assign stat_gnt0  = 32'd0;
   assign stat_gnt1  = 32'd0;
   assign stat_stall = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard testbench for dmem_arbiter
module tb_dmem_arbiter;

   logic             clk;
   logic             rst_n;
   logic [1:0]       m_req, m_we, m_is_cap;
   logic [1:0][3:0]  m_be;
   logic [1:0][31:0] m_addr;
   logic [1:0][32:0] m_wdata;
   logic [1:0][7:0]  m_flag;
   logic [1:0]       m_gnt, m_rvalid, m_err;
   logic [32:0]      m_rdata;
   logic             s_req, s_we, s_is_cap;
   logic [3:0]       s_be;
   logic [31:0]      s_addr;
   logic [32:0]      s_wdata;
   logic [7:0]       s_flag;
   logic             s_gnt, s_rvalid, s_err;
   logic [32:0]      s_rdata;
   logic             proto_err;
   logic [31:0]      stat_gnt0, stat_gnt1, stat_stall;

`ifdef DMEM_ARB_STATS_EN
   localparam logic [31:0] EXP_STALL = 32'd10;
   localparam logic [31:0] EXP_G0    = 32'd5;
   localparam logic [31:0] EXP_G1    = 32'd5;
`else
   localparam logic [31:0] EXP_STALL = 32'd0;
   localparam logic [31:0] EXP_G0    = 32'd0;
   localparam logic [31:0] EXP_G1    = 32'd0;
`endif

   typedef struct {
      logic        id;
      logic        err;
      logic [32:0] data;
   } resp_t;

   resp_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    resp_n = 0;
   int    g0 = 0;
   int    g1 = 0;

   dmem_arbiter #(.MAX_OUTST(4), .OID_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .m_req(m_req), .m_we(m_we), .m_is_cap(m_is_cap), .m_be(m_be),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_flag(m_flag),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata),
      .s_req(s_req), .s_we(s_we), .s_is_cap(s_is_cap), .s_be(s_be),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_flag(s_flag),
      .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata),
      .proto_err(proto_err),
      .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_stall(stat_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Response monitor: pops the scoreboard whenever the DUT routes a response.
   always @(negedge clk) begin
      resp_t e;
      if (rst_n && m_rvalid != 2'b00) begin
         if (exp_q.size() == 0) begin
            chk("mon.unexpected_rvalid", 64'(m_rvalid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("mon.rvalid", 64'(m_rvalid), e.id ? 64'd2 : 64'd1);
            chk("mon.err", 64'(m_err), e.err ? (e.id ? 64'd2 : 64'd1) : 64'd0);
            chk("mon.rdata", 64'(m_rdata), 64'(e.data));
         end
      end
   end

   // One bus cycle: drive at posedge+1, check address phase at negedge.
   // rid < 0 with rv=1 is a response the DUT must not route.
   task automatic cyc(input logic [1:0] req, input logic gnt, input logic rv,
                      input logic err, input int rid, input logic exp_sreq,
                      input int exp_sel, input string tag);
      logic [31:0] lo;
      logic [1:0]  exp_g;
      resp_t       r;
      @(posedge clk); #1;
      resp_n++;
      lo       = 32'hD000_0000 + 32'(resp_n);
      m_req    = req;
      s_gnt    = gnt;
      s_rvalid = rv;
      s_err    = err;
      s_rdata  = {lo[0], lo};
      if (rv && rid >= 0) begin
         r.id   = rid[0];
         r.err  = err;
         r.data = {lo[0], lo};
         exp_q.push_back(r);
      end
      @(negedge clk);
      exp_g = (exp_sreq && gnt) ? ((exp_sel != 0) ? 2'b10 : 2'b01) : 2'b00;
      chk({tag, ".s_req"}, 64'(s_req), 64'(exp_sreq));
      chk({tag, ".m_gnt"}, 64'(m_gnt), 64'(exp_g));
      if (exp_sreq) begin
         chk({tag, ".s_addr"}, 64'(s_addr), 64'(m_addr[exp_sel]));
         chk({tag, ".s_ctl"}, 64'({s_we, s_is_cap, s_be, s_flag, s_wdata}),
             64'({m_we[exp_sel], m_is_cap[exp_sel], m_be[exp_sel],
                  m_flag[exp_sel], m_wdata[exp_sel]}));
      end
      if (m_gnt[0]) g0++;
      if (m_gnt[1]) g1++;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n    = 1'b0;
      m_req    = 2'b00;
      s_gnt    = 1'b0;
      s_rvalid = 1'b0;
      s_err    = 1'b0;
      @(negedge clk);
      chk("rst.m_gnt", 64'(m_gnt), 64'd0);
      chk("rst.s_req", 64'(s_req), 64'd0);
      chk("rst.m_rvalid", 64'(m_rvalid), 64'd0);
      chk("rst.proto_err", 64'(proto_err), 64'd0);
      chk("rst.stats", {stat_gnt0, stat_gnt1} | 64'(stat_stall), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      m_req      = 2'b00;
      m_we       = 2'b10;
      m_is_cap   = 2'b01;
      m_be[0]    = 4'h3;
      m_be[1]    = 4'hC;
      m_addr[0]  = 32'h1000_0040;
      m_addr[1]  = 32'h2000_0080;
      m_wdata[0] = 33'h0_A5A5_0000;
      m_wdata[1] = 33'h1_5A5A_1111;
      m_flag[0]  = 8'h01;
      m_flag[1]  = 8'h04;
      s_gnt      = 1'b0;
      s_rvalid   = 1'b0;
      s_err      = 1'b0;
      s_rdata    = '0;
      do_reset();

      // Contended, always granted, response one cycle after each handshake
      g0 = 0; g1 = 0;
      for (int k = 0; k < 8; k++)
         cyc(2'b11, 1'b1, k > 0, 1'b0, (k - 1) % 2, 1'b1, k % 2, "rr");
      cyc(2'b00, 1'b0, 1'b1, 1'b0, 1, 1'b0, 0, "rr.tail");
      chk("rr.g0_count", 64'(g0), 64'd4);
      chk("rr.g1_count", 64'(g1), 64'd4);

      // Lock: give requester 1 the rr priority first, then stall requester 0
      cyc(2'b01, 1'b1, 1'b0, 1'b0, -1, 1'b1, 0, "lk.prep");
      cyc(2'b01, 1'b0, 1'b1, 1'b0, 0,  1'b1, 0, "lk.c0");
      cyc(2'b11, 1'b0, 1'b0, 1'b0, -1, 1'b1, 0, "lk.c1");
      cyc(2'b11, 1'b0, 1'b0, 1'b0, -1, 1'b1, 0, "lk.c2");
      cyc(2'b11, 1'b1, 1'b0, 1'b0, -1, 1'b1, 0, "lk.c3");
      cyc(2'b10, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1, "lk.c4");
      cyc(2'b00, 1'b0, 1'b1, 1'b0, 0,  1'b0, 0, "lk.r0");
      cyc(2'b00, 1'b0, 1'b1, 1'b0, 1,  1'b0, 0, "lk.r1");

      // Full: four handshakes, then blocked; a pop does not unblock same cycle
      for (int k = 0; k < 4; k++)
         cyc(2'b01, 1'b1, 1'b0, 1'b0, -1, 1'b1, 0, "full.fill");
      cyc(2'b01, 1'b1, 1'b0, 1'b0, -1, 1'b0, 0, "full.block");
      cyc(2'b01, 1'b1, 1'b1, 1'b0, 0,  1'b0, 0, "full.pop");
      cyc(2'b01, 1'b1, 1'b0, 1'b0, -1, 1'b1, 0, "full.reopen");
      for (int k = 0; k < 4; k++)
         cyc(2'b00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, "full.drain");

      // Interleaved IDs 1,0,0,1 with an error on the third response
      cyc(2'b10, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1, "il.i0");
      cyc(2'b01, 1'b1, 1'b0, 1'b0, -1, 1'b1, 0, "il.i1");
      cyc(2'b01, 1'b1, 1'b0, 1'b0, -1, 1'b1, 0, "il.i2");
      cyc(2'b10, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1, "il.i3");
      cyc(2'b00, 1'b0, 1'b1, 1'b0, 1, 1'b0, 0, "il.r0");
      cyc(2'b00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, "il.r1");
      cyc(2'b00, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, "il.r2");
      cyc(2'b00, 1'b0, 1'b1, 1'b0, 1, 1'b0, 0, "il.r3");

      // Response with nothing outstanding
      cyc(2'b00, 1'b0, 1'b1, 1'b0, -1, 1'b0, 0, "pe.stray");
      chk("pe.no_rvalid", 64'(m_rvalid), 64'd0);
      chk("pe.not_yet", 64'(proto_err), 64'd0);
      cyc(2'b00, 1'b0, 1'b0, 1'b0, -1, 1'b0, 0, "pe.idle");
      chk("pe.set", 64'(proto_err), 64'd1);
      cyc(2'b10, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1, "pe.req");
      cyc(2'b00, 1'b0, 1'b1, 1'b0, 1, 1'b0, 0, "pe.resp");
      chk("pe.sticky", 64'(proto_err), 64'd1);

      // Reset with transactions outstanding; a late response is a protocol error
      cyc(2'b01, 1'b1, 1'b0, 1'b0, -1, 1'b1, 0, "rd.h0");
      cyc(2'b01, 1'b1, 1'b0, 1'b0, -1, 1'b1, 0, "rd.h1");
      do_reset();
      cyc(2'b00, 1'b0, 1'b1, 1'b0, -1, 1'b0, 0, "rd.late");
      chk("rd.late_no_rvalid", 64'(m_rvalid), 64'd0);
      cyc(2'b00, 1'b0, 1'b0, 1'b0, -1, 1'b0, 0, "rd.idle");
      chk("rd.proto_err", 64'(proto_err), 64'd1);
      do_reset();

      // Ten contended cycles for the statistics counters (rr restarts at 0)
      for (int k = 0; k < 10; k++)
         cyc(2'b11, 1'b1, k > 0, 1'b0, (k - 1) % 2, 1'b1, k % 2, "st");
      cyc(2'b00, 1'b0, 1'b1, 1'b0, 1, 1'b0, 0, "st.tail");
      chk("st.stall", 64'(stat_stall), 64'(EXP_STALL));
      chk("st.gnt0", 64'(stat_gnt0), 64'(EXP_G0));
      chk("st.gnt1", 64'(stat_gnt1), 64'(EXP_G1));

      cyc(2'b00, 1'b0, 1'b0, 1'b0, -1, 1'b0, 0, "end");
      chk("sb.empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the testbench data memory's OBI-style data port.
- Requester 0 is the core LSU data port; requester 1 is a secondary master (TBRE/stack-zeroing agent or a TB DMA stimulus engine).
- Round-robin arbitration with address-phase locking; per-transaction requester IDs queued in order to route responses.
- Sits between the masters and the memory model; no address decoding of its own.

Parameters:
- MAX_OUTST, 4, maximum accepted-but-unresponded transactions; range 1..8.
- OID_W, 3, width of the outstanding counter; must satisfy 2**OID_W > MAX_OUTST.

Ports:
- clk  input  1  clock
- rst_n  input  1  async active-low reset
- m_req / m_we / m_is_cap  input  [1:0] each  per-requester request, write, capability-access flags
- m_be  input  2x4  per-requester byte enables
- m_addr  input  2x32  per-requester byte address
- m_wdata  input  2x33  per-requester write data; bit 32 is the tag
- m_flag  input  2x8  per-requester sideband flags (bit0 isr, bit2 stkz)
- m_gnt / m_rvalid / m_err  output  [1:0] each  per-requester grant, response valid, response error
- m_rdata  output  33  shared read data; qualify with m_rvalid
- s_req / s_we / s_is_cap  output  1 each  downstream request
- s_be  output  4  downstream byte enables
- s_addr  output  32  downstream byte address
- s_wdata  output  33  downstream write data
- s_flag  output  8  downstream sideband flags
- s_gnt / s_rvalid / s_err  input  1 each  downstream grant, response valid, response error
- s_rdata  input  33  downstream read data
- proto_err  output  1  sticky: downstream response arrived with no outstanding transaction
- stat_gnt0 / stat_gnt1 / stat_stall  output  32 each  statistics counters (see Optional Feature)

Behaviour:
- Reset values:
  - all outputs 0; outstanding FIFO empty; round-robin pointer rr = 0 (requester 0 favoured); lock cleared.
  - Reset mid-transaction discards all queued IDs; late downstream responses after reset set proto_err.
- Selection (combinational):
  - if lock is set, sel = locked requester;
  - else if exactly one m_req is high, sel = that requester;
  - else if both are high, sel = rr.
- Forwarding and full condition:
  - s_req = m_req[sel] & ~full, where full = (count == MAX_OUTST).
  - All downstream address-phase fields are muxed from sel.
- Grant: m_gnt[sel] = s_gnt & s_req; the other grant is 0. Zero added latency, combinational through-path.
- Lock (OBI address-phase stability):
  - when s_req=1 and s_gnt=0, register lock=1 and lock_id=sel; sel holds until granted;
  - lock clears on the grant cycle.
  - A requester that drops m_req while locked is illegal and is not checked.
  - While full, s_req=0 but the lock is retained.
- rr update: on every handshake (s_req & s_gnt), rr <= ~sel. A single active requester does not alter fairness beyond this rule.
- Outstanding FIFO:
  - depth MAX_OUTST, 1-bit entries, circular read/write pointers plus a count;
  - push sel on handshake; pop on s_rvalid;
  - simultaneous push and pop leaves count unchanged; pointers wrap modulo MAX_OUTST.
- Response routing:
  - m_rvalid[head] = s_rvalid; m_err[head] = s_err & s_rvalid; m_rdata = s_rdata.
  - Same cycle as the downstream response; responses are strictly in order.
- Empty case: s_rvalid while count==0 sets proto_err=1 (held until reset), raises no m_rvalid, and leaves the FIFO unchanged.
- A handshake and a response may occur in the same cycle, including at full: a pop at full does not unblock s_req in the same cycle; s_req re-asserts the next cycle.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - stat_gnt0 / stat_gnt1 count handshakes per requester;
  - stat_stall counts cycles where both m_req are high, or where a pending m_req is blocked by full;
  - all three are 32-bit saturating at 32'hFFFF_FFFF and reset to 0.
- Undefined: no counter flops; stat outputs tied to 0.

Test Plan:
- Both requesters pending at every cycle, s_gnt=1, immediate rvalid -> grants alternate 0,1,0,1…; 8 handshakes give 4 per requester; each response reaches the matching m_rvalid.
- Requester 0 pending, s_gnt held 0 for 3 cycles, requester 1 asserts in cycle 1 -> s_addr stays requester 0's for all stall cycles; requester 0 granted on cycle 4; requester 1 granted next.
- MAX_OUTST=4, s_gnt=1, no rvalid -> 4 handshakes, then s_req=0; one rvalid gives s_req=1 on the following cycle, not the same cycle.
- Interleaved IDs [1,0,0,1] outstanding, 4 rvalids with s_err on the 3rd -> m_rvalid sequence 1,0,0,1; m_err[0] asserted only on the 3rd response.
- s_rvalid with FIFO empty -> proto_err=1 and stays 1; no m_rvalid; a subsequent normal transaction completes correctly.
- DMEM_ARB_STATS_EN defined, 10 contended cycles -> stat_stall = 10 and stat_gnt0 + stat_gnt1 = handshake count; preload near saturation -> counters hold at 32'hFFFF_FFFF.
